// File: rtl/uart_autobaud.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | uart_autobaud: measures a 0x55 sync char and supplies uart_rx delay_frames.  |
// | Optional UART_AUTOBAUD_VERIFY_EN adds a per-interval check.  Rev 1.0         |
// +-----------------------------------------------------------------------------+
module uart_autobaud #(
    parameter int                         COUNTER_WIDTH = 16,
    parameter int                         IDLE_CYCLES   = 64,
    parameter int                         MIN_PERIOD    = 4,
    parameter logic [COUNTER_WIDTH-1:0]   DEFAULT_DELAY = 16'd433
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic                     uart_rxpin,
    input  logic                     relock,
    output logic [COUNTER_WIDTH-1:0] delay_frames,
    output logic                     locked,
    output logic                     lock_err,
    output logic                     uart_rst
);

    localparam int c_MW = COUNTER_WIDTH + 3;
    localparam int c_PW = COUNTER_WIDTH + 1;
    localparam int c_IW = $clog2(IDLE_CYCLES + 1);
    localparam logic [c_PW-1:0] c_PMAX = {1'b1, {COUNTER_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_MEASURE = 3'd2,
        S_EVAL    = 3'd3,
        S_LOCKED  = 3'd4
    } state_t;

    state_t            r_state;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_sync_prev;
    logic [c_MW-1:0]   r_meas;
    logic [2:0]        r_edges;
    logic [c_IW-1:0]   r_idle_cnt;

    logic              w_fall;
    logic              w_meas_max;
    logic [c_MW-1:0]   w_meas_next;
    logic [c_PW-1:0]   w_period;
    logic              w_bad_period;
    logic              w_ival_bad;

    assign w_fall      = r_sync_prev & ~r_sync2;
    assign w_meas_max  = &r_meas;
    assign w_meas_next = (ce && !w_meas_max) ? r_meas + 1'b1 : r_meas;
    // (M+4)>>3 == (M>>3) + M[2]: the +4 carries into bit 3 only when M[2] is set.
    assign w_period     = {1'b0, r_meas[c_MW-1:3]} + c_PW'(r_meas[2]);
    assign w_bad_period = (w_period < c_PW'(MIN_PERIOD)) || (w_period > c_PMAX);

`ifdef UART_AUTOBAUD_VERIFY_EN
    logic [c_MW-1:0] r_ival;
    logic [c_MW-1:0] r_i0;
    logic [c_MW-1:0] w_ival_now;
    logic [c_MW-1:0] w_diff;

    assign w_ival_now = (ce && !(&r_ival)) ? r_ival + 1'b1 : r_ival;
    assign w_diff     = (w_ival_now > r_i0) ? w_ival_now - r_i0 : r_i0 - w_ival_now;
    assign w_ival_bad = (r_edges != 3'd0) && (w_diff > (r_i0 >> 2));
`else
    assign w_ival_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_sync_prev  <= 1'b1;
            r_state      <= S_IDLE;
            r_meas       <= '0;
            r_edges      <= '0;
            r_idle_cnt   <= '0;
            delay_frames <= DEFAULT_DELAY;
            locked       <= 1'b0;
            lock_err     <= 1'b0;
            uart_rst     <= 1'b1;
`ifdef UART_AUTOBAUD_VERIFY_EN
            r_ival       <= '0;
            r_i0         <= '0;
`endif
        end else begin
            r_sync1     <= uart_rxpin;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
            lock_err    <= 1'b0;
            r_idle_cnt  <= '0;

            case (r_state)
                S_IDLE: begin
                    if (!r_sync2) begin
                        r_idle_cnt <= '0;
                    end else if (ce) begin
                        if (r_idle_cnt == c_IW'(IDLE_CYCLES - 1)) begin
                            r_state <= S_ARMED;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                    end else begin
                        r_idle_cnt <= r_idle_cnt;
                    end
                end

                S_ARMED: begin
                    if (w_fall) begin
                        r_meas  <= '0;
                        r_edges <= '0;
`ifdef UART_AUTOBAUD_VERIFY_EN
                        r_ival  <= '0;
`endif
                        r_state <= S_MEASURE;
                    end
                end

                S_MEASURE: begin
                    if (w_meas_max) begin
                        lock_err <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        r_meas <= w_meas_next;
`ifdef UART_AUTOBAUD_VERIFY_EN
                        r_ival <= w_ival_now;
`endif
                        if (w_fall) begin
`ifdef UART_AUTOBAUD_VERIFY_EN
                            r_ival <= '0;
                            if (r_edges == 3'd0) begin
                                r_i0 <= w_ival_now;
                            end
`endif
                            if (w_ival_bad) begin
                                lock_err <= 1'b1;
                                r_state  <= S_IDLE;
                            end else begin
                                // Fourth fall after the first closes an 8-bit-time window.
                                r_edges <= r_edges + 3'd1;
                                if (r_edges == 3'd3) begin
                                    r_state <= S_EVAL;
                                end
                            end
                        end
                    end
                end

                S_EVAL: begin
                    if (w_bad_period) begin
                        lock_err <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        delay_frames <= COUNTER_WIDTH'(w_period - c_PW'(1));
                        locked       <= 1'b1;
                        uart_rst     <= 1'b0;
                        r_state      <= S_LOCKED;
                    end
                end

                S_LOCKED: begin
                    if (relock) begin
                        locked   <= 1'b0;
                        uart_rst <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end

                default: begin
                    locked   <= 1'b0;
                    uart_rst <= 1'b1;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_autobaud.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_uart_autobaud: randomized 0x55 sync frames against an event-level model.  |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module tb_uart_autobaud;

    localparam int CW   = 10;
    localparam int MW   = CW + 3;
    localparam int MAXM = (1 << MW) - 1;
    localparam int IDLE = 64;
    localparam int MINP = 4;
    localparam int DEF  = 433;

    localparam int K_LOCK   = 0;
    localparam int K_ERR    = 1;
    localparam int K_RELOCK = 2;
    localparam int K_RESET  = 3;

    logic          clk    = 1'b0;
    logic          rst    = 1'b1;
    logic          ce     = 1'b1;
    logic          rxpin  = 1'b1;
    logic          relock = 1'b0;
    logic [CW-1:0] delay_frames;
    logic          locked;
    logic          lock_err;
    logic          uart_rst;

    uart_autobaud #(
        .COUNTER_WIDTH (CW),
        .IDLE_CYCLES   (IDLE),
        .MIN_PERIOD    (MINP),
        .DEFAULT_DELAY (10'd433)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .uart_rxpin   (rxpin),
        .relock       (relock),
        .delay_frames (delay_frames),
        .locked       (locked),
        .lock_err     (lock_err),
        .uart_rst     (uart_rst)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int at;
        int kind;
        int dly;
    } ev_t;

    ev_t evq[$];
    bit  m_locked    = 1'b0;
    int  m_delay     = DEF;
    bit  pred_locked = 1'b0;
    int  vectors     = 0;
    int  miscompares = 0;
    int  err_seen    = 0;

    bit wp[$];
    bit wc[$];

    function automatic void post(int at, int kind, int dly);
        ev_t e;
        e.at   = at;
        e.kind = kind;
        e.dly  = dly;
        evq.push_back(e);
    endfunction

    // Model state advances at the cycle each expected event becomes visible.
    initial begin
        ev_t e;
        bit  exp_err;
        forever begin
            @(negedge clk);
            exp_err = 1'b0;
            while (evq.size() > 0 && evq[0].at <= cyc) begin
                e = evq.pop_front();
                case (e.kind)
                    K_LOCK:   begin m_locked = 1'b1; m_delay = e.dly; end
                    K_ERR:    exp_err = (e.at == cyc);
                    K_RELOCK: m_locked = 1'b0;
                    default:  begin m_locked = 1'b0; m_delay = DEF; end
                endcase
            end
            if (lock_err === 1'b1) err_seen++;
            vectors++;
            if (locked !== m_locked || uart_rst !== !m_locked ||
                delay_frames !== CW'(m_delay) || lock_err !== exp_err) begin
                miscompares++;
                $display("FAIL cycle %0d outputs: locked=%b uart_rst=%b delay=%0d lock_err=%b, required locked=%0d uart_rst=%0d delay=%0d lock_err=%0d",
                         cyc, locked, uart_rst, delay_frames, lock_err,
                         m_locked, !m_locked, m_delay, exp_err);
            end
        end
    end

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    function automatic int cnt_ce(int a, int b);
        int s = 0;
        for (int j = a; j <= b && j < wc.size(); j++) s += int'(wc[j]);
        return s;
    endfunction

    task automatic add(input bit p, input int n, input bit rce);
        for (int i = 0; i < n; i++) begin
            wp.push_back(p);
            wc.push_back(rce ? ($urandom_range(3) != 0) : 1'b1);
        end
    endtask

    task automatic add_frame(input int w[10], input bit rce);
        logic [7:0] ch;
        bit         lvl;
        ch = 8'h55;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      lvl = 1'b0;
            else if (k == 9) lvl = 1'b1;
            else             lvl = ch[k-1];
            add(lvl, w[k], rce && (k < 9));
        end
    endtask

    // Wave cycle j is driven after posedge n0+j; a fall there is seen by the
    // controller at posedge n0+j+3 (two sync flops plus edge register).
    task automatic run_wave(input bit active);
        int n0;
        int falls[$];
        int iv[5];
        int m;
        int p;
        int d;
        bit prev;
        bit done;
        @(posedge clk);
        #1;
        n0   = cyc;
        prev = rxpin;
        for (int j = 0; j < wp.size(); j++) begin
            if (prev && !wp[j]) falls.push_back(j);
            prev = wp[j];
        end
        if (active && falls.size() > 0) begin
            done = 1'b0;
            for (int k = 1; k < falls.size() && k <= 4 && !done; k++) begin
                iv[k] = cnt_ce(falls[k-1] + 3, falls[k] + 2);
`ifdef UART_AUTOBAUD_VERIFY_EN
                d = iv[k] - iv[1];
                if (d < 0) d = -d;
                if (k >= 2 && d > (iv[1] >> 2)) begin
                    post(n0 + falls[k] + 3, K_ERR, 0);
                    done = 1'b1;
                end
`endif
                if (!done && k == 4) begin
                    m = iv[1] + iv[2] + iv[3] + iv[4];
                    p = (m + 4) >> 3;
                    if (p < MINP || p - 1 > (1 << CW) - 1) begin
                        post(n0 + falls[4] + 4, K_ERR, 0);
                    end else begin
                        post(n0 + falls[4] + 4, K_LOCK, p - 1);
                        pred_locked = 1'b1;
                    end
                    done = 1'b1;
                end
            end
            if (!done) begin
                m = 0;
                for (int j = falls[0] + 3; j < wc.size(); j++) begin
                    m += int'(wc[j]);
                    if (m == MAXM) begin
                        post(n0 + j + 2, K_ERR, 0);
                        break;
                    end
                end
            end
        end
        for (int j = 0; j < wp.size(); j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
            end
            rxpin = wp[j];
            ce    = wc[j];
        end
        wp.delete();
        wc.delete();
    endtask

    task automatic send(input int gap, input int w[10], input bit rce);
        add(1'b1, gap, 1'b0);
        add_frame(w, rce);
        add(1'b1, 10, 1'b0);
        run_wave(gap >= 100 && !pred_locked);
        @(negedge clk);
    endtask

    task automatic do_relock();
        @(posedge clk);
        #1;
        relock = 1'b1;
        if (pred_locked) post(cyc + 1, K_RELOCK, 0);
        pred_locked = 1'b0;
        @(posedge clk);
        #1;
        relock = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            post(cyc + 1, K_RESET, 0);
        end
        pred_locked = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic fill(output int w[10], input int v);
        for (int k = 0; k < 10; k++) w[k] = v;
    endtask

    initial begin
        int w[10];
        int e0;
        int base;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        lit("reset_delay", 32'(delay_frames), 433);
        lit("reset_locked", 32'(locked), 0);
        lit("reset_uart_rst", 32'(uart_rst), 1);
        lit("reset_lock_err", 32'(lock_err), 0);

        // Too fast: M=24 -> P=3 rejected, default delay kept.
        e0 = err_seen;
        fill(w, 3);
        send(100, w, 1'b0);
        lit("fast_err_pulses", 32'(err_seen - e0), 1);
        lit("fast_delay", 32'(delay_frames), 433);

        // Only ~43 high cycles since the error: must not arm.
        fill(w, 16);
        send(30, w, 1'b0);
        lit("not_armed_locked", 32'(locked), 0);

        e0 = err_seen;
        send(100, w, 1'b0);
        lit("lock16_delay", 32'(delay_frames), 15);
        lit("lock16_locked", 32'(locked), 1);
        lit("lock16_uart_rst", 32'(uart_rst), 0);
        lit("lock16_no_err", 32'(err_seen - e0), 0);

        do_relock();
        lit("relock_locked", 32'(locked), 0);
        lit("relock_uart_rst", 32'(uart_rst), 1);
        lit("relock_delay", 32'(delay_frames), 15);
        do_relock();

        // Rounding: M=131 -> P=16.
        w[1] = 17; w[4] = 17; w[7] = 17;
        send(100, w, 1'b0);
        lit("round_delay", 32'(delay_frames), 15);

        fill(w, 32);
        send(100, w, 1'b0);
        lit("locked_ignores_rx", 32'(delay_frames), 15);
        do_relock();

        // MIN_PERIOD boundary: M=27 rejected, M=28 accepted as P=4.
        w = '{3, 4, 3, 4, 3, 4, 3, 3, 3, 3};
        send(100, w, 1'b0);
        lit("m27_delay", 32'(delay_frames), 15);
        w = '{3, 4, 3, 4, 3, 4, 3, 4, 3, 3};
        send(100, w, 1'b0);
        lit("m28_delay", 32'(delay_frames), 3);
        do_relock();

        // Saturation timeout then a clean lock.
        e0 = err_seen;
        add(1'b1, 100, 1'b0);
        add(1'b0, MAXM + 40, 1'b0);
        add(1'b1, 5, 1'b0);
        run_wave(1'b1);
        @(negedge clk);
        lit("timeout_err_pulses", 32'(err_seen - e0), 1);
        lit("timeout_locked", 32'(locked), 0);
        fill(w, 20);
        send(100, w, 1'b0);
        lit("after_timeout_delay", 32'(delay_frames), 19);
        do_relock();

        fill(w, 32);
        send(100, w, 1'b0);
        lit("lock32_delay", 32'(delay_frames), 31);
        do_relock();

        // Reset mid-measure.
        e0 = err_seen;
        add(1'b1, 100, 1'b0);
        add(1'b0, 32, 1'b0);
        add(1'b1, 32, 1'b0);
        add(1'b0, 32, 1'b0);
        add(1'b1, 10, 1'b0);
        run_wave(1'b1);
        do_reset(2);
        lit("abort_delay", 32'(delay_frames), 433);
        lit("abort_no_err", 32'(err_seen - e0), 0);

        // Third interval 48 instead of 32.
        e0 = err_seen;
        fill(w, 16);
        w[4] = 24; w[5] = 24;
        send(100, w, 1'b0);
`ifdef UART_AUTOBAUD_VERIFY_EN
        lit("verify_err_pulses", 32'(err_seen - e0), 1);
        lit("verify_locked", 32'(locked), 0);
`else
        lit("skew_delay", 32'(delay_frames), 17);
`endif

        for (int r = 0; r < 12; r++) begin
            if (pred_locked) do_relock();
            base = $urandom_range(40, 6);
            for (int k = 0; k < 10; k++) begin
                w[k] = base + $urandom_range(2, 0) - 1;
                if (w[k] < 1) w[k] = 1;
            end
            send(100, w, r[0]);
        end

        repeat (8) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
